// File: rtl/missile_fire_ctrl_if.sv
// Mover-side link of the missile fire controller: fire/kill strobes out,
// draw-enable and position feedback in.
interface missile_fire_ctrl_if;
  logic        fireReq;
  logic        missileKill;
  logic        missileDrawEn;
  logic [10:0] missileTopLeftX;
  logic [10:0] missileTopLeftY;

  modport master (
    output fireReq,
    output missileKill,
    input  missileDrawEn,
    input  missileTopLeftX,
    input  missileTopLeftY
  );

  modport slave (
    input  fireReq,
    input  missileKill,
    output missileDrawEn,
    output missileTopLeftX,
    output missileTopLeftY
  );
endinterface

// File: rtl/missile_fire_ctrl.sv
// Per-tank missile fire request, flight supervision and frame-based cooldown.
// Optional macro MISSILE_AUTOFIRE_EN: fire on the key level instead of its rising edge.
module missile_fire_ctrl #(
  parameter int COOLDOWN_FRAMES   = 15,
  parameter int MAX_FLIGHT_FRAMES = 90,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480,
  parameter int FIRE_ACK_CYCLES   = 3
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       keyIn,
  missile_fire_ctrl_if.master        mover,
  output logic                       ready,
  output logic [7:0]                 shotCount
);

  // Frame limits saturate at the 8-bit counter range; a zero ack window acts as one cycle.
  localparam int COOL_C   = (COOLDOWN_FRAMES > 255) ? 255 : COOLDOWN_FRAMES;
  localparam int FLIGHT_C = (MAX_FLIGHT_FRAMES > 255) ? 255 : MAX_FLIGHT_FRAMES;
  localparam int ACK_C    = (FIRE_ACK_CYCLES < 1) ? 1 :
                            (FIRE_ACK_CYCLES > 255) ? 255 : FIRE_ACK_CYCLES;
  localparam logic [7:0]  coolLim   = COOL_C[7:0];
  localparam logic [7:0]  flightLim = FLIGHT_C[7:0];
  localparam logic [7:0]  ackLast   = 8'(ACK_C - 1);
  localparam logic [10:0] xLim      = SCREEN_W[10:0];
  localparam logic [10:0] yLim      = SCREEN_H[10:0];
  localparam bit          timeoutEn = (MAX_FLIGHT_FRAMES != 0);

  typedef enum logic [2:0] {IDLE, FIRE, ACK_WAIT, FLIGHT, KILL, COOLDOWN} state_t;

  state_t     state, nextState;
  logic [7:0] frameCnt;
  logic [7:0] ackCnt;
  logic       shootTrig;
  logic       outOfBounds;

`ifdef MISSILE_AUTOFIRE_EN
  assign shootTrig = keyIn;
`else
  logic keyPrev;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) keyPrev <= 1'b0;
    else         keyPrev <= keyIn;
  end

  assign shootTrig = keyIn & ~keyPrev;
`endif

  // Negative positions wrap to large unsigned values and land out of bounds.
  assign outOfBounds = (mover.missileTopLeftX >= xLim) || (mover.missileTopLeftY >= yLim);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (shootTrig) nextState = FIRE;
      FIRE:     nextState = ACK_WAIT;
      ACK_WAIT: begin
        if (mover.missileDrawEn)  nextState = FLIGHT;
        else if (ackCnt == ackLast) nextState = IDLE;
      end
      FLIGHT: begin
        if (!mover.missileDrawEn)                      nextState = COOLDOWN;
        else if (outOfBounds)                          nextState = KILL;
        else if (timeoutEn && (frameCnt == flightLim)) nextState = KILL;
      end
      KILL:     nextState = COOLDOWN;
      COOLDOWN: if (frameCnt == coolLim) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Strobes and ready are registered from the next state so they follow the state exactly.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state             <= IDLE;
      mover.fireReq     <= 1'b0;
      mover.missileKill <= 1'b0;
      ready             <= 1'b1;
      shotCount         <= 8'd0;
      frameCnt          <= 8'd0;
      ackCnt            <= 8'd0;
    end else begin
      state             <= nextState;
      mover.fireReq     <= (nextState == FIRE);
      mover.missileKill <= (nextState == KILL);
      ready             <= (nextState == IDLE);
      if (nextState == FIRE)
        shotCount <= shotCount + 8'd1;
      if (nextState != state)
        frameCnt <= 8'd0;
      else if (startOfFrame && (frameCnt != 8'hFF) &&
               ((state == FLIGHT) || (state == COOLDOWN)))
        frameCnt <= frameCnt + 8'd1;
      if (state != ACK_WAIT)
        ackCnt <= 8'd0;
      else
        ackCnt <= ackCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_missile_fire_ctrl.sv
// Scoreboard bench for missile_fire_ctrl: expected fire/kill strobes are queued
// by the stimulus and matched by a monitor; levels are checked directly.
module tb_missile_fire_ctrl;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       keyIn;
  logic       ready;
  logic [7:0] shotCount;

  missile_fire_ctrl_if mif();

  missile_fire_ctrl #(
    .COOLDOWN_FRAMES   (15),
    .MAX_FLIGHT_FRAMES (4),
    .SCREEN_W          (640),
    .SCREEN_H          (480),
    .FIRE_ACK_CYCLES   (3)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .keyIn        (keyIn),
    .mover        (mif.master),
    .ready        (ready),
    .shotCount    (shotCount)
  );

  typedef struct {
    bit isKill;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe seen must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetN && (mif.fireReq || mif.missileKill)) begin
      tests++;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL strobe: got kill=%0d at cyc %0d, expected no strobe",
                 mif.missileKill, cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if ((mif.missileKill != e.isKill) || (mif.fireReq == e.isKill) || (cyc != e.cyc)) begin
          fails++;
          $display("[TB] FAIL strobe: got kill=%0d fire=%0d cyc=%0d, expected kill=%0d cyc=%0d",
                   mif.missileKill, mif.fireReq, cyc, e.isKill, e.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic k, input logic s, input logic d,
                               input logic [10:0] x, input logic [10:0] y);
    keyIn               = k;
    startOfFrame        = s;
    mif.missileDrawEn   = d;
    mif.missileTopLeftX = x;
    mif.missileTopLeftY = y;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic s);
    applyStimulus(keyIn, s, mif.missileDrawEn, mif.missileTopLeftX, mif.missileTopLeftY);
  endtask

  task automatic runFrames(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      for (int j = 1; j < gap; j++) tick(1'b0);
    end
  endtask

  // Release, press, let the mover ack in the first ACK_WAIT cycle; ends in FLIGHT.
  task automatic fireShot();
    applyStimulus(1'b0, 1'b0, 1'b0, 11'd100, 11'd100);
    expQ.push_back('{isKill: 1'b0, cyc: cyc + 1});
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd100, 11'd100);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd100, 11'd100);
    applyStimulus(1'b1, 1'b0, 1'b1, 11'd100, 11'd100);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN              = 1'b0;
    keyIn               = 1'b0;
    startOfFrame        = 1'b0;
    mif.missileDrawEn   = 1'b0;
    mif.missileTopLeftX = 11'd100;
    mif.missileTopLeftY = 11'd100;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReady", ready, 1);
    checkOutput("resetFireReq", mif.fireReq, 0);
    checkOutput("resetKill", mif.missileKill, 0);
    checkOutput("resetShotCount", shotCount, 0);
    resetN = 1'b1;
    repeat (5) tick(1'b0);

    // Shot 1: fire, ack, then X steps out past the right edge.
    fireShot();
    checkOutput("flightShotCount", shotCount, 1);
    checkOutput("flightReady", ready, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 11'd630, 11'd100);
    applyStimulus(1'b1, 1'b0, 1'b1, 11'd635, 11'd100);
    expQ.push_back('{isKill: 1'b1, cyc: cyc + 1});
    applyStimulus(1'b1, 1'b0, 1'b1, 11'd641, 11'd100);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd100, 11'd100);
    checkOutput("cooldownReady", ready, 0);
    // A fresh key edge during COOLDOWN must be dropped.
    applyStimulus(1'b0, 1'b0, 1'b0, 11'd100, 11'd100);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd100, 11'd100);
    runFrames(14, 3);
    checkOutput("cooldown14Ready", ready, 0);
    runFrames(1, 3);
    checkOutput("cooldown15Ready", ready, 1);
    checkOutput("edgeInCooldownShotCount", shotCount, 1);

    // Shot 2: Y wraps negative.
    fireShot();
    expQ.push_back('{isKill: 1'b1, cyc: cyc + 1});
    applyStimulus(1'b1, 1'b0, 1'b1, 11'd100, 11'd2040);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd100, 11'd100);
    runFrames(15, 3);
    checkOutput("yWrapReady", ready, 1);
    checkOutput("yWrapShotCount", shotCount, 2);

    // Shot 3: in-bounds flight times out after the 4th frame.
    fireShot();
    runFrames(3, 4);
    expQ.push_back('{isKill: 1'b1, cyc: cyc + 2});
    runFrames(1, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd100, 11'd100);
    runFrames(15, 3);
    checkOutput("timeoutReady", ready, 1);
    checkOutput("timeoutShotCount", shotCount, 3);

    // Shot 4: draw-enable drops together with out-of-bounds: no kill, straight to COOLDOWN.
    fireShot();
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd700, 11'd100);
    tick(1'b0);
    checkOutput("dropReady", ready, 0);
    runFrames(14, 3);
    checkOutput("drop14Ready", ready, 0);
    runFrames(1, 3);
    checkOutput("dropReadyAfter", ready, 1);
    checkOutput("dropShotCount", shotCount, 4);

    // Shot 5: no ack within the window.
    applyStimulus(1'b0, 1'b0, 1'b0, 11'd100, 11'd100);
    expQ.push_back('{isKill: 1'b0, cyc: cyc + 1});
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd100, 11'd100);
    repeat (3) tick(1'b0);
    checkOutput("noAckWaitReady", ready, 0);
    tick(1'b0);
    checkOutput("noAckReady", ready, 1);
    checkOutput("noAckShotCount", shotCount, 5);

    // Shot 6: key held for 100 frames fires exactly once.
    fireShot();
    for (int i = 0; i < 100; i++) begin
      if (i == 3) expQ.push_back('{isKill: 1'b1, cyc: cyc + 2});
      runFrames(1, 5);
      if (i == 3) mif.missileDrawEn = 1'b0;
    end
    checkOutput("heldReady", ready, 1);
    checkOutput("heldShotCount", shotCount, 6);

    // Reset mid-flight: back to IDLE with no kill strobe.
    fireShot();
    tick(1'b0);
    resetN = 1'b0;
    mif.missileDrawEn = 1'b0;
    #1;
    checkOutput("midResetReady", ready, 1);
    checkOutput("midResetKill", mif.missileKill, 0);
    checkOutput("midResetShotCount", shotCount, 0);
    repeat (2) tick(1'b0);
    resetN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 11'd100, 11'd100);
    repeat (4) tick(1'b0);
    checkOutput("postResetReady", ready, 1);

    checkOutput("pendingStrobes", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
